add_seq_ctrl: RTL and testbench

Multi-cycle sequencer that adds two wide operands (WORDS × N bits) with a single shared N-bit ripple-carry slice. It processes one slice per clock, least-significant first, and feeds the carry back through a register between slices. It sits between a requesting unit and the adder datapath, trading latency for area, and delivers a (WORDS·N+1)-bit sum with a one-cycle done pulse.

---
 rtl/add_seq_ctrl_pkg.sv | 14 +
 rtl/add_seq_ctrl_if.sv | 30 +++
 rtl/add_seq_ctrl_slice.sv | 24 ++
 rtl/add_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the sliced multi-word adder sequencer.
// Holds the controller state encoding and default geometry.
package add_seq_ctrl_pkg;

    localparam int N_DEF     = 4;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle between a requesting unit and the sequencer.
// The requester drives the master side, the sequencer the slave side.
interface add_seq_ctrl_if
    import add_seq_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
);
    localparam int W = N * WORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W:0]   sum;

    modport master (
        output start, a, b, ci,
        input  ready, busy, done, sum
    );

    modport slave (
        input  start, a, b, ci,
        output ready, busy, done, sum
    );

endinterface

// File: rtl/add_seq_ctrl_slice.sv
// Combinational N-bit ripple-carry adder slice.
// One full-adder cell per bit, carry chained from bit 0 upward.
module add_slice #(
    parameter int N = 4
) (
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequencer adding two WORDS*N-bit operands through one shared N-bit
// slice, one slice per clock, LSB first, carry held in a register.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input logic          clk,
    input logic          rst,
    add_seq_ctrl_if.slave bus
);

    localparam int CW = $clog2(WORDS);

    typedef logic [WORDS-1:0][N-1:0] words_t;

    state_t  state_q, state_d;
    words_t  a_q, a_d;
    words_t  b_q, b_d;
    words_t  sum_w_q, sum_w_d;
    logic    sum_c_q, sum_c_d;
    logic    carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ready;
    logic          busy;
    logic          done;
    logic          accept;
    logic          last;
    logic [N-1:0]  slice_s;
    logic          slice_cout;

    assign accept = bus.start & ready;
    assign last   = (cnt_q == CW'(WORDS - 1));

    add_slice #(.N(N)) u_slice (
        .cin  (carry_q),
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: DONE may re-accept directly, skipping IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    begin ready = 1'b1; done = 1'b1; end
            default: ready = 1'b0;
        endcase
    end

    // Datapath: latch on accept, then one slice per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_w_d = sum_w_q;
        sum_c_d = sum_c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.ci;
            sum_w_d = '0;
            sum_c_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sum_w_d[cnt_q] = slice_s;
            carry_d        = slice_cout;
            cnt_d          = last ? '0 : cnt_q + CW'(1);
            if (last) sum_c_d = slice_cout;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_w_q <= '0;
            sum_c_q <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_w_q <= sum_w_d;
            sum_c_q <= sum_c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready = ready;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.sum   = {sum_c_q, sum_w_q};

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Testbench for add_seq_ctrl: directed scenarios on a 4x4 instance,
// randomised operations on a 3x5 instance against a + b + ci.
module tb_add_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    add_seq_ctrl_if #(.N(4), .WORDS(4)) bus4 ();
    add_seq_ctrl_if #(.N(3), .WORDS(5)) bus5 ();

    add_seq_ctrl #(.N(4), .WORDS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    add_seq_ctrl #(.N(3), .WORDS(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    localparam int BOUND = 20;

    function automatic logic [16:0] ref16(logic [15:0] a, logic [15:0] b,
                                          logic ci);
        return {1'b0, a} + {1'b0, b} + 17'(ci);
    endfunction

    function automatic logic [15:0] ref15(logic [14:0] a, logic [14:0] b,
                                          logic ci);
        return {1'b0, a} + {1'b0, b} + 16'(ci);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept4(input logic [15:0] a, input logic [15:0] b,
                           input logic ci);
        bus4.a     = a;
        bus4.b     = b;
        bus4.ci    = ci;
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
    endtask

    task automatic wait_done4(output int cyc);
        cyc = 0;
        while (bus4.done !== 1'b1 && cyc < BOUND) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
        bus5.start = 1'b0; bus5.a = '0; bus5.b = '0; bus5.ci = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus4.ready, bus4.busy, bus4.done} !== 3'b100 ||
            bus4.sum !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/busy/done=%b sum=%h want 100 sum=00000",
                     {bus4.ready, bus4.busy, bus4.done}, bus4.sum);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_chk++;
            if ({bus4.ready, bus4.busy, bus4.done} !== 3'b100 ||
                bus4.sum !== 17'h0) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: rdy/busy/done=%b sum=%h want 100 sum=00000",
                         i, {bus4.ready, bus4.busy, bus4.done}, bus4.sum);
            end
        end
    endtask

    task automatic test_basic();
        int cyc;
        logic [16:0] exp;
        exp = ref16(16'h1234, 16'h4321, 1'b0);
        accept4(16'h1234, 16'h4321, 1'b0);
        n_chk++;
        if (bus4.busy !== 1'b1 || bus4.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b ready=%b want busy=1 ready=0",
                     bus4.busy, bus4.ready);
        end
        wait_done4(cyc);
        n_chk++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles want 4", cyc);
        end
        n_chk++;
        if (bus4.sum !== exp || bus4.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_sum: sum=%h ready=%b want %h ready=1",
                     bus4.sum, bus4.ready, exp);
        end
        step();
        n_chk++;
        if (bus4.done !== 1'b0 || bus4.busy !== 1'b0 ||
            bus4.ready !== 1'b1 || bus4.sum !== exp) begin
            n_fail++;
            $display("FAIL basic_pulse: done=%b busy=%b ready=%b sum=%h want 0 0 1 %h",
                     bus4.done, bus4.busy, bus4.ready, bus4.sum, exp);
        end
    endtask

    task automatic test_carry();
        int cyc;
        logic [15:0] av [2] = '{16'hFFFF, 16'hFFFF};
        logic [15:0] bv [2] = '{16'h0000, 16'hFFFF};
        logic [16:0] exp;
        for (int i = 0; i < 2; i++) begin
            exp = ref16(av[i], bv[i], 1'b1);
            accept4(av[i], bv[i], 1'b1);
            wait_done4(cyc);
            n_chk++;
            if (cyc != 4 || bus4.sum !== exp) begin
                n_fail++;
                $display("FAIL carry[%0d]: cyc=%0d sum=%h want cyc=4 sum=%h",
                         i, cyc, bus4.sum, exp);
            end
            step();
        end
    endtask

    task automatic test_ignore_run();
        int cyc;
        int pulses;
        accept4(16'h0001, 16'h0001, 1'b0);
        bus4.start = 1'b1;
        bus4.a     = 16'hFFFF;
        bus4.b     = 16'hFFFF;
        bus4.ci    = 1'b1;
        wait_done4(cyc);
        bus4.start = 1'b0;
        n_chk++;
        if (cyc != 4 || bus4.sum !== 17'h00002) begin
            n_fail++;
            $display("FAIL ignore_sum: cyc=%0d sum=%h want cyc=4 sum=00002",
                     cyc, bus4.sum);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus4.done === 1'b1 || bus4.busy === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses != 0 || bus4.sum !== 17'h00002) begin
            n_fail++;
            $display("FAIL ignore_extra: active_cycles=%0d sum=%h want 0 sum=00002",
                     pulses, bus4.sum);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [16:0] exp1;
        logic [16:0] exp2;
        exp1 = ref16(16'h1111, 16'h2222, 1'b0);
        exp2 = ref16(16'h00FF, 16'h0001, 1'b0);
        accept4(16'h1111, 16'h2222, 1'b0);
        bus4.start = 1'b1;
        bus4.a     = 16'h00FF;
        bus4.b     = 16'h0001;
        bus4.ci    = 1'b0;
        wait_done4(cyc);
        n_chk++;
        if (cyc != 4 || bus4.sum !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: cyc=%0d sum=%h want cyc=4 sum=%h",
                     cyc, bus4.sum, exp1);
        end
        step();
        bus4.start = 1'b0;
        n_chk++;
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: busy=%b done=%b want busy=1 done=0",
                     bus4.busy, bus4.done);
        end
        wait_done4(cyc);
        n_chk++;
        if (cyc + 1 != 5 || bus4.sum !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: gap=%0d sum=%h want gap=5 sum=%h",
                     cyc + 1, bus4.sum, exp2);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int pulses;
        logic [16:0] exp;
        exp = ref16(16'hABCD, 16'h1234, 1'b1);
        accept4(16'hABCD, 16'h1234, 1'b1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus4.sum !== 17'h0 || bus4.done !== 1'b0 ||
            bus4.ready !== 1'b1 || bus4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: sum=%h done=%b ready=%b busy=%b want 00000 0 1 0",
                     bus4.sum, bus4.done, bus4.ready, bus4.busy);
        end
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus4.done === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses != 0 || bus4.sum !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_no_done: pulses=%0d sum=%h want 0 sum=00000",
                     pulses, bus4.sum);
        end
        accept4(16'hABCD, 16'h1234, 1'b1);
        wait_done4(cyc);
        n_chk++;
        if (cyc != 4 || bus4.sum !== exp) begin
            n_fail++;
            $display("FAIL reset_recover: cyc=%0d sum=%h want cyc=4 sum=%h",
                     cyc, bus4.sum, exp);
        end
        step();
    endtask

    task automatic test_random();
        logic [14:0] ra;
        logic [14:0] rb;
        logic        rc;
        logic [15:0] exp;
        int          cyc;
        for (int op = 0; op < 1000; op++) begin
            ra  = 15'($urandom);
            rb  = 15'($urandom);
            rc  = 1'($urandom);
            exp = ref15(ra, rb, rc);
            bus5.a     = ra;
            bus5.b     = rb;
            bus5.ci    = rc;
            bus5.start = 1'b1;
            step();
            bus5.start = 1'b0;
            cyc = 0;
            while (bus5.done !== 1'b1 && cyc < BOUND) begin
                bus5.a  = 15'($urandom);
                bus5.b  = 15'($urandom);
                bus5.ci = 1'($urandom);
                step();
                cyc++;
            end
            n_chk++;
            if (cyc != 5 || bus5.sum !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%h b=%h ci=%b cyc=%0d sum=%h want cyc=5 sum=%h",
                         op, ra, rb, rc, cyc, bus5.sum, exp);
            end
            if ($urandom_range(0, 1) == 0) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
